change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Payout controller downstream of vending_machine.
- Accepts a change amount in rupees and pays it out greedily as 5/2/1 coins, one at a time, through a coin-hopper handshake.
- Tracks a per-denomination inventory and reports any amount it could not pay.
- Uses the same one-hot coin encoding as vending_machine: 100 = ₹5, 010 = ₹2, 001 = ₹1.

Parameters:
INV_W, 6, width of each inventory counter
INIT_5, 10, ₹5 coins loaded at reset/refill (must fit INV_W)
INIT_2, 10, ₹2 coins loaded at reset/refill
INIT_1, 10, ₹1 coins loaded at reset/refill
ACK_TIMEOUT, 15, max cycles waited for each hopper handshake phase

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; change_amt sampled with it
change_amt  in  4  rupees to pay, 0..15
refill  in  1  reload all inventories to INIT_*, clear fault
eject  out  3  one-hot coin release request to hopper
eject_ack  in  1  hopper four-phase acknowledge
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
shortfall  out  4  unpaid rupees; valid from done until next accepted start
fault  out  1  sticky hopper-timeout flag
inv_5, inv_2, inv_1  out  INV_W each  current coin counts

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; eject=000, busy=0, done=0, shortfall=0, fault=0.
  - inv_* = INIT_*; remaining=0; timeout counter=0.
  - Applies immediately, including mid-payout: eject drops without waiting for a clock edge.
- States: IDLE, SELECT, EJECT, RELEASE, DONE.
- IDLE:
  - start=1 loads remaining=change_amt and moves to SELECT; shortfall clears to 0.
  - start is ignored outside IDLE.
  - refill=1 in IDLE reloads inventories and clears fault; refill is ignored outside IDLE.
  - start and refill together: both take effect on the same edge, and SELECT sees the refilled counts.
- SELECT, exactly one cycle:
  - If fault=1, remaining is left unchanged and the block goes to DONE.
  - If remaining==0, go to DONE.
  - Otherwise pick the largest coin c with value<=remaining and inv_c>0, and go to EJECT.
  - If no coin qualifies, go to DONE with remaining unchanged (no backtracking; e.g. remaining 3, inv_1=0 pays ₹2, then leaves 1 short).
- EJECT:
  - eject=selected one-hot, held stable.
  - On a sampled eject_ack=1: inv_c-=1, remaining-=value, eject=000, next state RELEASE.
- RELEASE: eject=000; waits for eject_ack=0, then returns to SELECT.
- Timeout:
  - A counter is cleared on entry to EJECT and to RELEASE.
  - If ACK_TIMEOUT cycles elapse without the awaited ack level: fault=1, eject=000, go to DONE.
  - An EJECT timeout means the coin is not counted as paid.
- DONE, one cycle: done=1, shortfall=remaining, then IDLE.
- Latency:
  - start with nothing payable: start sampled at edge N, SELECT at N+1, done high in cycle N+2.
  - Per coin: ≥3 cycles (EJECT ≥1, RELEASE ≥1, SELECT 1).
- Inventory never underflows, since a coin is only selected if its count is >0. Remaining arithmetic is 4-bit and cannot underflow.
- eject is always one-hot or 000, and never changes value while in EJECT.
- fault stays set until refill or reset. While fault=1, every start completes with no ejects and shortfall=change_amt.

Test Plan:
- Reset, start amt=8; hopper acks 2 cycles after eject and drops ack 1 cycle later -> eject sequence 100, 010, 001; done; shortfall=0; inv_5=9, inv_2=9, inv_1=9.
- start amt=0 -> no eject; done pulse exactly 2 cycles after start; shortfall=0; busy high for 2 cycles.
- INIT_2=1: start amt=4 -> eject 010, 001, 001; inv_2=0, inv_1=8; shortfall=0. Repeat amt=2 -> eject 001, 001; inv_1=6.
- INIT_1=0: start amt=3 -> eject 010 only; done with shortfall=1; inv_2=9.
- Hopper never acks, amt=5 -> eject=100 held 15 cycles, then 000; fault=1; done with shortfall=5; inv_5=10. Next start amt=3 -> done with shortfall=3, no eject. refill -> fault=0; amt=3 pays 010, 001.
- reset_n low for 1 cycle while eject=100 -> eject=000 and busy=0 immediately; inv_*=10; shortfall=0; start after release works normally. Also: a start pulse during a payout is ignored.

Source files
------------

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// change_dispenser : greedy 5/2/1 coin payout controller driving a coin hopper
//                    over a four-phase handshake, with per-coin inventory.
// Revision: 1.0
// ============================================================================
module change_dispenser #(
  parameter int INV_W       = 6,
  parameter int INIT_5      = 10,
  parameter int INIT_2      = 10,
  parameter int INIT_1      = 10,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       change_amt,
  input  logic             refill,
  output logic [2:0]       eject,
  input  logic             eject_ack,
  output logic             busy,
  output logic             done,
  output logic [3:0]       shortfall,
  output logic             fault,
  output logic [INV_W-1:0] inv_5,
  output logic [INV_W-1:0] inv_2,
  output logic [INV_W-1:0] inv_1
);

  localparam int               TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [INV_W-1:0] C_INIT_5 = INV_W'(INIT_5);
  localparam logic [INV_W-1:0] C_INIT_2 = INV_W'(INIT_2);
  localparam logic [INV_W-1:0] C_INIT_1 = INV_W'(INIT_1);
  localparam logic [2:0]       COIN_5   = 3'b100;
  localparam logic [2:0]       COIN_2   = 3'b010;
  localparam logic [2:0]       COIN_1   = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_EJECT   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [2:0]       sel_q, sel_d;
  logic [INV_W-1:0] inv5_q, inv5_d, inv2_q, inv2_d, inv1_q, inv1_d;
  logic             fault_q, fault_d;
  logic [3:0]       sf_q, sf_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       coin_val;

  always_comb begin
    case (sel_q)
      COIN_5:  coin_val = 4'd5;
      COIN_2:  coin_val = 4'd2;
      default: coin_val = 4'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    inv5_d  = inv5_q;
    inv2_d  = inv2_q;
    inv1_d  = inv1_q;
    fault_d = fault_q;
    sf_d    = sf_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (refill) begin
          inv5_d  = C_INIT_5;
          inv2_d  = C_INIT_2;
          inv1_d  = C_INIT_1;
          fault_d = 1'b0;
        end
        if (start) begin
          rem_d   = change_amt;
          sf_d    = 4'd0;
          state_d = S_SELECT;
        end
      end

      S_SELECT: begin
        tmo_d = '0;
        // Greedy without backtracking: a missing small coin just leaves a shortfall.
        if (fault_q || rem_q == 4'd0) begin
          state_d = S_DONE;
        end else if (rem_q >= 4'd5 && inv5_q != '0) begin
          sel_d   = COIN_5;
          state_d = S_EJECT;
        end else if (rem_q >= 4'd2 && inv2_q != '0) begin
          sel_d   = COIN_2;
          state_d = S_EJECT;
        end else if (inv1_q != '0) begin
          sel_d   = COIN_1;
          state_d = S_EJECT;
        end else begin
          state_d = S_DONE;
        end
      end

      S_EJECT: begin
        if (eject_ack) begin
          if (sel_q[2]) inv5_d = inv5_q - 1'b1;
          if (sel_q[1]) inv2_d = inv2_q - 1'b1;
          if (sel_q[0]) inv1_d = inv1_q - 1'b1;
          rem_d   = rem_q - coin_val;
          tmo_d   = '0;
          state_d = S_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_RELEASE: begin
        if (!eject_ack) begin
          state_d = S_SELECT;
        end else if (tmo_q == TMO_LAST) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Latch the unpaid amount as DONE is entered so it is valid with the pulse.
    if (state_d == S_DONE && state_q != S_DONE) begin
      sf_d = rem_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= 4'd0;
      sel_q   <= 3'b000;
      inv5_q  <= C_INIT_5;
      inv2_q  <= C_INIT_2;
      inv1_q  <= C_INIT_1;
      fault_q <= 1'b0;
      sf_q    <= 4'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      inv5_q  <= inv5_d;
      inv2_q  <= inv2_d;
      inv1_q  <= inv1_d;
      fault_q <= fault_d;
      sf_q    <= sf_d;
      tmo_q   <= tmo_d;
    end
  end

  // Decoded from state so an async reset drops the coin request at once.
  assign eject     = (state_q == S_EJECT) ? sel_q : 3'b000;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign shortfall = sf_q;
  assign fault     = fault_q;
  assign inv_5     = inv5_q;
  assign inv_2     = inv2_q;
  assign inv_1     = inv1_q;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// tb_change_dispenser : table-driven payout vectors with coin/done scoreboard.
// Revision: 1.0
// ============================================================================
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] change_amt;
  logic       refill;
  logic [2:0] eject;
  logic       eject_ack;
  logic       busy;
  logic       done;
  logic [3:0] shortfall;
  logic       fault;
  logic [5:0] inv_5, inv_2, inv_1;
  logic       hop_en;

  change_dispenser dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .change_amt (change_amt),
    .refill     (refill),
    .eject      (eject),
    .eject_ack  (eject_ack),
    .busy       (busy),
    .done       (done),
    .shortfall  (shortfall),
    .fault      (fault),
    .inv_5      (inv_5),
    .inv_2      (inv_2),
    .inv_1      (inv_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         refill;
    logic [3:0] amt;
    int         n5, n2, n1;
    int         sf;
    int         i5, i2, i1;
  } row_t;

  typedef struct {
    int sf;
    int inv;
    int flt;
  } done_t;

  logic [2:0] coin_q[$];
  done_t      done_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         done_cnt = 0;
  logic [2:0] prev_eject = 3'b000;
  int         hop_cnt;
  row_t       rows[24];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic int pk(input int i5, input int i2, input int i1);
    return (i5 << 12) | (i2 << 6) | i1;
  endfunction

  function automatic row_t mk(input bit rf, input int amt, input int n5, input int n2,
                              input int n1, input int sf, input int i5, input int i2,
                              input int i1);
    row_t r;
    r.refill = rf; r.amt = 4'(amt);
    r.n5 = n5; r.n2 = n2; r.n1 = n1; r.sf = sf;
    r.i5 = i5; r.i2 = i2; r.i1 = i1;
    return r;
  endfunction

  // Hopper: raise ack two cycles after a coin request, drop it one cycle after release.
  always @(posedge clk) begin
    if (!reset_n || !hop_en) begin
      eject_ack <= 1'b0;
      hop_cnt   <= 0;
    end else if (eject != 3'b000 && !eject_ack) begin
      if (hop_cnt == 1) begin
        eject_ack <= 1'b1;
        hop_cnt   <= 0;
      end else begin
        hop_cnt <= hop_cnt + 1;
      end
    end else if (eject == 3'b000 && eject_ack) begin
      eject_ack <= 1'b0;
    end else begin
      hop_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    done_t d;
    logic [2:0] c;
    if (eject != 3'b000 && prev_eject == 3'b000) begin
      if (coin_q.size() == 0) begin
        n_checks++;
        $display("FAIL coin_unexpected: got %b expected none", eject);
      end else begin
        c = coin_q.pop_front();
        check("coin", int'(eject), int'(c));
      end
    end
    prev_eject <= eject;
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        n_checks++;
        $display("FAIL done_unexpected: got done=1 expected 0");
      end else begin
        d = done_q.pop_front();
        check("shortfall", int'(shortfall), d.sf);
        check("inventory", int'({inv_5, inv_2, inv_1}), d.inv);
        check("fault_at_done", int'(fault), d.flt);
      end
    end
  end

  task automatic expect_done(input int sf, input int inv, input int flt);
    done_t d;
    d.sf = sf; d.inv = inv; d.flt = flt;
    done_q.push_back(d);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) begin
      fail_now("done_timeout");
      coin_q.delete();
      done_q.delete();
    end else begin
      check("coins_left", coin_q.size(), 0);
    end
  endtask

  task automatic run_row(input row_t r, input bit poke);
    int d0;
    for (int k = 0; k < r.n5; k++) coin_q.push_back(3'b100);
    for (int k = 0; k < r.n2; k++) coin_q.push_back(3'b010);
    for (int k = 0; k < r.n1; k++) coin_q.push_back(3'b001);
    expect_done(r.sf, pk(r.i5, r.i2, r.i1), 0);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; change_amt = r.amt; refill = r.refill;
    @(negedge clk);
    start = 1'b0; refill = 1'b0;
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1; change_amt = 4'd15; refill = 1'b1;
      @(negedge clk);
      start = 1'b0; refill = 1'b0;
    end
    wait_done(d0);
  endtask

  initial begin
    int d0;
    int held;

    rows[0]  = mk(0, 8,  1, 1, 1, 0, 9, 9, 9);
    rows[1]  = mk(0, 0,  0, 0, 0, 0, 9, 9, 9);
    rows[2]  = mk(0, 15, 3, 0, 0, 0, 6, 9, 9);
    rows[3]  = mk(0, 4,  0, 2, 0, 0, 6, 7, 9);
    rows[4]  = mk(0, 9,  1, 2, 0, 0, 5, 5, 9);
    rows[5]  = mk(0, 13, 2, 1, 1, 0, 3, 4, 8);
    rows[6]  = mk(0, 12, 2, 1, 0, 0, 1, 3, 8);
    rows[7]  = mk(0, 11, 1, 3, 0, 0, 0, 0, 8);
    rows[8]  = mk(0, 6,  0, 0, 6, 0, 0, 0, 2);
    rows[9]  = mk(0, 5,  0, 0, 2, 3, 0, 0, 0);
    rows[10] = mk(1, 0,  0, 0, 0, 0, 10, 10, 10);
    for (int k = 0; k < 10; k++) rows[11 + k] = mk(0, 1, 0, 0, 1, 0, 10, 10, 9 - k);
    rows[21] = mk(0, 3,  0, 1, 0, 1, 10, 9, 0);
    rows[22] = mk(0, 1,  0, 0, 0, 1, 10, 9, 0);
    rows[23] = mk(1, 15, 3, 0, 0, 0, 7, 10, 10);

    reset_n = 1'b0; start = 1'b0; change_amt = 4'd0; refill = 1'b0; hop_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_eject", int'(eject), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_shortfall", int'(shortfall), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_inventory", int'({inv_5, inv_2, inv_1}), pk(10, 10, 10));
    reset_n = 1'b1;

    // Nothing-to-pay latency: SELECT then DONE, busy for exactly two cycles.
    expect_done(0, pk(10, 10, 10), 0);
    @(negedge clk);
    start = 1'b1; change_amt = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("lat_busy_sel", int'(busy), 1);
    check("lat_done_sel", int'(done), 0);
    @(negedge clk);
    check("lat_busy_done", int'(busy), 1);
    check("lat_done_pulse", int'(done), 1);
    @(negedge clk);
    check("lat_busy_idle", int'(busy), 0);
    check("lat_done_idle", int'(done), 0);

    for (int i = 0; i < 24; i++) run_row(rows[i], 1'b0);

    // Hopper never acknowledges: request held ACK_TIMEOUT cycles, then fault.
    hop_en = 1'b0;
    coin_q.push_back(3'b100);
    expect_done(5, pk(7, 10, 10), 1);
    d0 = done_cnt; held = 0;
    @(negedge clk);
    start = 1'b1; change_amt = 4'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      if (eject == 3'b100) held++;
    end
    if (done_cnt == d0) fail_now("tmo_done");
    check("tmo_hold_cycles", held, 15);
    check("tmo_fault_sticky", int'(fault), 1);

    expect_done(3, pk(7, 10, 10), 1);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; change_amt = 4'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0);

    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    check("refill_fault", int'(fault), 0);
    check("refill_inventory", int'({inv_5, inv_2, inv_1}), pk(10, 10, 10));
    hop_en = 1'b1;
    run_row(mk(0, 3, 0, 1, 1, 0, 10, 9, 9), 1'b0);

    // Async reset in the middle of a coin request.
    hop_en = 1'b0;
    coin_q.push_back(3'b100);
    @(negedge clk);
    start = 1'b1; change_amt = 4'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && eject != 3'b100; i++) @(negedge clk);
    if (eject != 3'b100) fail_now("rst_mid_eject");
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("amid_eject", int'(eject), 0);
    check("amid_busy", int'(busy), 0);
    check("amid_shortfall", int'(shortfall), 0);
    check("amid_inventory", int'({inv_5, inv_2, inv_1}), pk(10, 10, 10));
    @(posedge clk); #1;
    reset_n = 1'b1;
    hop_en = 1'b1;
    check("amid_coins_left", coin_q.size(), 0);
    run_row(mk(0, 8, 1, 1, 1, 0, 9, 9, 9), 1'b1);

    repeat (3) @(negedge clk);
    check("done_records_left", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
